frv_mem_arbiter: RTL and testbench
==================================

# frv_mem_arbiter

Shares one memory port between the frv_core instruction fetch (`imem_*`) and load/store (`dmem_*`) channels. It uses the core's req/gnt and recv/ack handshake on all three sides. An in-order owner FIFO tracks outstanding transactions, so every response returns to the channel that issued it. The block sits between one `frv_core` and a unified memory or BRAM, and is instantiated once per core in the dual-core miter.

## Interface
Parameters:
- `XL`, default 31: data/address width minus one.
- `OUTSTANDING`, default 2: maximum number of accepted transactions without a completed response. Legal range 1..4.

Ports (where a line names an `imem`/`dmem` pair, the line applies to both channels):
- `g_clk`  input  1  single clock, rising edge.
- `g_resetn`  input  1  asynchronous, active-low reset.
- `imem_req` / `dmem_req`  input  1  request valid; held stable until the matching gnt.
- `imem_wen` / `dmem_wen`  input  1  write enable.
- `imem_strb` / `dmem_strb`  input  4  write byte strobe.
- `imem_wdata` / `dmem_wdata`  input  XL+1  write data.
- `imem_addr` / `dmem_addr`  input  XL+1  address.
- `imem_gnt` / `dmem_gnt`  output  1  request accepted this cycle.
- `imem_recv` / `dmem_recv`  output  1  response valid.
- `imem_ack` / `dmem_ack`  input  1  response accepted.
- `imem_error` / `dmem_error`  output  1  response error, valid while recv is high.
- `imem_rdata` / `dmem_rdata`  output  XL+1  response read data.
- `mem_req`, `mem_wen`, `mem_strb`, `mem_wdata`, `mem_addr`  output  (1, 1, 4, XL+1, XL+1)  downstream request.
- `mem_gnt`  input  1  downstream accepts the request.
- `mem_recv`, `mem_error`, `mem_rdata`  input  (1, 1, XL+1)  downstream response.
- `mem_ack`  output  1  response accepted.

## Operation
- **Selection.** Each cycle the arbiter selects `sel` ∈ {I, D} from the active requests.
  - `mem_req` = request of `sel` AND NOT full.
  - `mem_wen`, `mem_strb`, `mem_wdata`, `mem_addr` always mirror `sel`.
- **Grant.** `x_gnt` = `mem_gnt` AND `mem_req` AND (`sel` == x). The non-selected channel's gnt is 0.
- **Lock FSM.**
  - States: NONE, LOCK_I, LOCK_D.
  - NONE → LOCK_x when `sel`=x drives `mem_req` and `mem_gnt`=0.
  - LOCK_x → NONE on `mem_req` AND `mem_gnt`.
  - While in LOCK_x, `sel` is forced to x regardless of priority.
- **Owner FIFO.**
  - Depth OUTSTANDING, 1-bit entries, count 0..OUTSTANDING.
  - Push `sel` on `mem_req` AND `mem_gnt`.
  - Pop on `mem_recv` AND `mem_ack`.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo OUTSTANDING.
- **Full.** When count == OUTSTANDING, `mem_req`=0 and both gnts are 0. A pop in the same cycle does not bypass this; issue resumes the next cycle.
- **Response routing by FIFO head.**
  - `x_recv` = `mem_recv` AND non-empty AND head == x.
  - `x_rdata` = `mem_rdata` and `x_error` = `mem_error`, broadcast to both channels; each channel qualifies them with its own recv.
  - `mem_ack` = ack of the head owner.
- **Spurious response.** If `mem_recv` arrives while the FIFO is empty, `mem_ack`=1 (drained), no channel sees recv, and count is unchanged.
- **Ordering.** Responses must return from memory in the order the requests were accepted.

## Timing
- **Request path:** zero latency. req → `mem_req` and `mem_gnt` → `x_gnt` are combinational.
- **Response path:** zero latency. `mem_recv` → `x_recv` and `x_ack` → `mem_ack` are combinational.
- **State update:** FIFO, count, lock state and round-robin pointer update on the rising `g_clk` edge.
- **Reset:** on `g_resetn` low, state clears immediately without a clock edge.
  - count=0, FIFO pointers=0, lock=NONE, round-robin last-granted=D.
  - Resulting outputs: all gnt/recv=0, `mem_req`=0, `mem_ack`=0.
- **Reset mid-transaction:** in-flight transactions are abandoned; responses that arrive afterwards are drained as spurious.
- **Single channel:** one requesting channel with `mem_gnt` tied to 1 sustains one grant per cycle until full.

## Configuration
- `FRV_MEM_ARB_ROUND_ROBIN_EN` defined:
  - With NONE and both channels requesting, select the channel not granted last.
  - The last-granted pointer updates on each `mem_req` AND `mem_gnt`.
- Undefined:
  - Fixed priority, D over I; the pointer is not implemented.
  - Lock and full behaviour are unchanged.

## Test plan
1. **Basic fetch.** Only `imem_req`=1, addr 0x8000_0000, `mem_gnt`=1 → same cycle `mem_req`=1, `mem_addr`=0x8000_0000, `imem_gnt`=1, `dmem_gnt`=0. Next cycle `mem_recv`=1, rdata 0x0000_0013, `imem_ack`=1 → `imem_recv`=1, `imem_rdata`=0x13, `mem_ack`=1, `dmem_recv`=0, count returns to 0.
2. **Priority.** Both channels request continuously; `mem_gnt`, `mem_recv` and ack held at 1 from the cycle after the first grant.
   - Macro undefined → D granted every cycle.
   - Macro defined → grants I, D, I, D starting from reset.
3. **Lock.** `imem_req` only, `mem_gnt`=0 for 3 cycles; `dmem_req` rises in cycle 2; `mem_gnt`=1 in cycle 4 → `mem_addr` stays at the imem address and the cycle-4 grant goes to I. D is granted on the next cycle.
4. **Full.** OUTSTANDING=2: two grants with no recv → count=2 and `mem_req`=0 while `imem_req`=1. One `mem_recv`&&`mem_ack` → `mem_req`=1 on the following cycle.
5. **Ordering and error.** Grant I, then D. Responses 0xAAAA_AAAA (error 0) then 0x5555_5555 (error 1) → `imem_recv` with 0xAAAA_AAAA first, then `dmem_recv` with 0x5555_5555 and `dmem_error`=1. `imem_error` is never qualified by `imem_recv`.
6. **Async reset.** Drop `g_resetn` between clock edges with count=1 and lock=LOCK_D → count=0 and lock=NONE immediately, without a clock edge. A later `mem_recv` is acked (`mem_ack`=1) and not forwarded to either channel.

Source files
------------

// File: rtl/frv_mem_arbiter.sv
// Two-channel (imem/dmem) arbiter onto one memory port, with an in-order owner FIFO for response routing.
// Optional build macro FRV_MEM_ARB_ROUND_ROBIN_EN: round-robin between channels instead of fixed D-over-I priority.
module frv_mem_arbiter #(
  parameter int XL          = 31,
  parameter int OUTSTANDING = 2
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  input  logic          imem_req,
  input  logic          imem_wen,
  input  logic [3:0]    imem_strb,
  input  logic [XL:0]   imem_wdata,
  input  logic [XL:0]   imem_addr,
  output logic          imem_gnt,
  output logic          imem_recv,
  input  logic          imem_ack,
  output logic          imem_error,
  output logic [XL:0]   imem_rdata,
  input  logic          dmem_req,
  input  logic          dmem_wen,
  input  logic [3:0]    dmem_strb,
  input  logic [XL:0]   dmem_wdata,
  input  logic [XL:0]   dmem_addr,
  output logic          dmem_gnt,
  output logic          dmem_recv,
  input  logic          dmem_ack,
  output logic          dmem_error,
  output logic [XL:0]   dmem_rdata,
  output logic          mem_req,
  output logic          mem_wen,
  output logic [3:0]    mem_strb,
  output logic [XL:0]   mem_wdata,
  output logic [XL:0]   mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_recv,
  input  logic          mem_error,
  input  logic [XL:0]   mem_rdata,
  output logic          mem_ack
);

  localparam logic [1:0] NONE   = 2'd0;
  localparam logic [1:0] LOCK_I = 2'd1;
  localparam logic [1:0] LOCK_D = 2'd2;

  localparam logic [2:0] FULL_CNT = 3'(OUTSTANDING);
  localparam logic [1:0] LAST_IDX = 2'(OUTSTANDING - 1);

  logic [1:0] lock_reg, lock_next;
  logic [2:0] count_reg, count_next;
  logic [1:0] wr_ptr_reg, rd_ptr_reg;
  logic [3:0] owner_reg, owner_next;

  logic sel_is_d, sel_req, full, empty, head_is_d, push, pop;

`ifdef FRV_MEM_ARB_ROUND_ROBIN_EN
  logic last_d_reg;
`endif

  // A locked channel keeps the port until its pending request is accepted.
  always_comb begin
    sel_is_d = 1'b0;
    case (lock_reg)
      LOCK_I: sel_is_d = 1'b0;
      LOCK_D: sel_is_d = 1'b1;
      default: begin
`ifdef FRV_MEM_ARB_ROUND_ROBIN_EN
        if (imem_req && dmem_req) sel_is_d = ~last_d_reg;
        else                      sel_is_d = dmem_req;
`else
        sel_is_d = dmem_req;
`endif
      end
    endcase
  end

  assign full      = (count_reg == FULL_CNT);
  assign empty     = (count_reg == 3'd0);
  assign sel_req   = sel_is_d ? dmem_req : imem_req;
  assign mem_req   = sel_req && !full;
  assign mem_wen   = sel_is_d ? dmem_wen   : imem_wen;
  assign mem_strb  = sel_is_d ? dmem_strb  : imem_strb;
  assign mem_wdata = sel_is_d ? dmem_wdata : imem_wdata;
  assign mem_addr  = sel_is_d ? dmem_addr  : imem_addr;

  assign push     = mem_req && mem_gnt;
  assign imem_gnt = push && !sel_is_d;
  assign dmem_gnt = push && sel_is_d;

  assign head_is_d  = owner_reg[rd_ptr_reg];
  assign imem_recv  = mem_recv && !empty && !head_is_d;
  assign dmem_recv  = mem_recv && !empty && head_is_d;
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;
  assign imem_error = mem_error;
  assign dmem_error = mem_error;
  // With nothing outstanding the response has no owner and is simply drained.
  assign mem_ack    = empty ? mem_recv : (head_is_d ? dmem_ack : imem_ack);
  assign pop        = mem_recv && mem_ack && !empty;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_owner
      assign owner_next[gi] = (push && wr_ptr_reg == 2'(gi)) ? sel_is_d : owner_reg[gi];
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 3'd1;
      2'b01:   count_next = count_reg - 3'd1;
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    lock_next = lock_reg;
    if (lock_reg == NONE) begin
      if (mem_req && !mem_gnt) lock_next = sel_is_d ? LOCK_D : LOCK_I;
    end else if (push) begin
      lock_next = NONE;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      lock_reg   <= NONE;
      count_reg  <= 3'd0;
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      owner_reg  <= 4'd0;
    end else begin
      lock_reg  <= lock_next;
      count_reg <= count_next;
      owner_reg <= owner_next;
      if (push) wr_ptr_reg <= (wr_ptr_reg == LAST_IDX) ? 2'd0 : wr_ptr_reg + 2'd1;
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == LAST_IDX) ? 2'd0 : rd_ptr_reg + 2'd1;
    end
  end

`ifdef FRV_MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn)  last_d_reg <= 1'b1;
    else if (push)  last_d_reg <= sel_is_d;
  end
`endif

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// Directed bench for frv_mem_arbiter: fetch, priority, lock, full, ordering/error and async reset.
module tb_frv_mem_arbiter;
  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        imem_req, imem_wen, imem_ack, dmem_req, dmem_wen, dmem_ack;
  logic [3:0]  imem_strb, dmem_strb, mem_strb;
  logic [31:0] imem_wdata, imem_addr, dmem_wdata, dmem_addr;
  logic        imem_gnt, imem_recv, imem_error, dmem_gnt, dmem_recv, dmem_error;
  logic [31:0] imem_rdata, dmem_rdata;
  logic        mem_req, mem_wen, mem_gnt, mem_recv, mem_error, mem_ack;
  logic [31:0] mem_wdata, mem_addr, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  frv_mem_arbiter #(.XL(31), .OUTSTANDING(2)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .imem_req(imem_req), .imem_wen(imem_wen), .imem_strb(imem_strb),
    .imem_wdata(imem_wdata), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_recv(imem_recv), .imem_ack(imem_ack), .imem_error(imem_error),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_wdata(dmem_wdata), .dmem_addr(dmem_addr), .dmem_gnt(dmem_gnt),
    .dmem_recv(dmem_recv), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
    .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_recv(mem_recv), .mem_error(mem_error), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic idle();
    imem_req = 1'b0; imem_wen = 1'b0; imem_strb = 4'h0; imem_wdata = 32'h0;
    imem_addr = 32'h0; imem_ack = 1'b0;
    dmem_req = 1'b0; dmem_wen = 1'b0; dmem_strb = 4'h0; dmem_wdata = 32'h0;
    dmem_addr = 32'h0; dmem_ack = 1'b0;
    mem_gnt = 1'b0; mem_recv = 1'b0; mem_error = 1'b0; mem_rdata = 32'h0;
  endtask

  // Advance to one time unit after the next rising edge.
  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    g_resetn = 1'b0;
    #2;
    g_resetn = 1'b1;
    tick();
  endtask

  logic exp_d [4];

  initial begin
    idle();
    g_resetn = 1'b0;
    #3;
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst gnt", 32'({imem_gnt, dmem_gnt}), 32'd0);
    chk("rst recv", 32'({imem_recv, dmem_recv}), 32'd0);
    chk("rst mem_ack", 32'(mem_ack), 32'd0);
    g_resetn = 1'b1;
    tick();

    // Basic fetch
    imem_req = 1'b1; imem_addr = 32'h8000_0000; mem_gnt = 1'b1;
    #1;
    chk("t1 mem_req", 32'(mem_req), 32'd1);
    chk("t1 mem_addr", mem_addr, 32'h8000_0000);
    chk("t1 imem_gnt", 32'(imem_gnt), 32'd1);
    chk("t1 dmem_gnt", 32'(dmem_gnt), 32'd0);
    tick();
    imem_req = 1'b0; mem_gnt = 1'b0; mem_recv = 1'b1; mem_rdata = 32'h0000_0013; imem_ack = 1'b1;
    #1;
    chk("t1 imem_recv", 32'(imem_recv), 32'd1);
    chk("t1 imem_rdata", imem_rdata, 32'h13);
    chk("t1 mem_ack", 32'(mem_ack), 32'd1);
    chk("t1 dmem_recv", 32'(dmem_recv), 32'd0);
    tick();
    imem_ack = 1'b0;
    #1;
    chk("t1 empty drain ack", 32'(mem_ack), 32'd1);
    chk("t1 empty no recv", 32'(imem_recv), 32'd0);

    // Priority, starting from reset
    tick();
    do_reset();
    for (int k = 0; k < 4; k++) begin
`ifdef FRV_MEM_ARB_ROUND_ROBIN_EN
      exp_d[k] = (k % 2) == 1;
`else
      exp_d[k] = 1'b1;
`endif
    end
    for (int k = 0; k < 4; k++) begin
      imem_req = 1'b1; imem_addr = 32'h100;
      dmem_req = 1'b1; dmem_addr = 32'h200;
      mem_gnt = 1'b1;
      mem_recv = (k > 0); imem_ack = (k > 0); dmem_ack = (k > 0);
      #1;
      chk($sformatf("t2 dmem_gnt c%0d", k), 32'(dmem_gnt), 32'(exp_d[k]));
      chk($sformatf("t2 imem_gnt c%0d", k), 32'(imem_gnt), 32'(!exp_d[k]));
      if (k > 0)
        chk($sformatf("t2 recv c%0d", k), 32'({imem_recv, dmem_recv}),
            exp_d[k-1] ? 32'd1 : 32'd2);
      tick();
    end

    // Lock
    do_reset();
    imem_req = 1'b1; imem_addr = 32'h300; dmem_addr = 32'h400;
    #1;
    chk("t3 c1 addr", mem_addr, 32'h300);
    tick();
    dmem_req = 1'b1;
    #1;
    chk("t3 c2 addr", mem_addr, 32'h300);
    chk("t3 c2 dgnt", 32'(dmem_gnt), 32'd0);
    tick();
    #1;
    chk("t3 c3 addr", mem_addr, 32'h300);
    tick();
    mem_gnt = 1'b1;
    #1;
    chk("t3 c4 gnt", 32'({imem_gnt, dmem_gnt}), 32'd2);
    chk("t3 c4 addr", mem_addr, 32'h300);
    tick();
    imem_req = 1'b0;
    #1;
    chk("t3 c5 dgnt", 32'(dmem_gnt), 32'd1);
    chk("t3 c5 addr", mem_addr, 32'h400);
    tick();

    // Full
    do_reset();
    imem_req = 1'b1; imem_addr = 32'h500; mem_gnt = 1'b1;
    #1;
    chk("t4 g1", 32'(imem_gnt), 32'd1);
    tick();
    #1;
    chk("t4 g2", 32'(imem_gnt), 32'd1);
    tick();
    mem_recv = 1'b1; imem_ack = 1'b1;
    #1;
    chk("t4 full mem_req", 32'(mem_req), 32'd0);
    chk("t4 full gnt", 32'(imem_gnt), 32'd0);
    chk("t4 full recv", 32'(imem_recv), 32'd1);
    tick();
    mem_recv = 1'b0; imem_ack = 1'b0;
    #1;
    chk("t4 resume mem_req", 32'(mem_req), 32'd1);
    chk("t4 resume gnt", 32'(imem_gnt), 32'd1);
    tick();

    // Ordering and error
    do_reset();
    imem_req = 1'b1; imem_addr = 32'h10; mem_gnt = 1'b1;
    #1;
    chk("t5 igrant", 32'(imem_gnt), 32'd1);
    tick();
    imem_req = 1'b0; dmem_req = 1'b1; dmem_addr = 32'h20;
    #1;
    chk("t5 dgrant", 32'(dmem_gnt), 32'd1);
    tick();
    dmem_req = 1'b0; mem_gnt = 1'b0; mem_recv = 1'b1; mem_rdata = 32'hAAAA_AAAA;
    mem_error = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
    #1;
    chk("t5 r1 recv", 32'({imem_recv, dmem_recv}), 32'd2);
    chk("t5 r1 rdata", imem_rdata, 32'hAAAA_AAAA);
    chk("t5 r1 error", 32'(imem_error), 32'd0);
    tick();
    mem_rdata = 32'h5555_5555; mem_error = 1'b1;
    #1;
    chk("t5 r2 recv", 32'({imem_recv, dmem_recv}), 32'd1);
    chk("t5 r2 rdata", dmem_rdata, 32'h5555_5555);
    chk("t5 r2 derror", 32'(dmem_error), 32'd1);
    chk("t5 r2 ierror bcast", 32'(imem_error), 32'd1);
    tick();

    // Async reset with one outstanding D and a D lock
    do_reset();
    dmem_req = 1'b1; dmem_addr = 32'h600; mem_gnt = 1'b1;
    #1;
    chk("t6 dgrant", 32'(dmem_gnt), 32'd1);
    tick();
    mem_gnt = 1'b0;
    tick();
    dmem_req = 1'b0; imem_req = 1'b1; imem_addr = 32'h700;
    #1;
    chk("t6 locked mem_req", 32'(mem_req), 32'd0);
    g_resetn = 1'b0;
    #1;
    chk("t6 rst mem_req", 32'(mem_req), 32'd1);
    chk("t6 rst addr", mem_addr, 32'h700);
    imem_req = 1'b0; mem_recv = 1'b1;
    #1;
    chk("t6 drain ack", 32'(mem_ack), 32'd1);
    chk("t6 drain recv", 32'({imem_recv, dmem_recv}), 32'd0);
    g_resetn = 1'b1;
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
